// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq : multi-cycle integer divide sequencer for DIV / DIVU in EX.
//
// Runs a restoring division, producing one quotient bit per clock, and returns
// {remainder, quotient} for the HI/LO write path. Signed operation divides the
// operand magnitudes and then fixes up the signs: the quotient is negative when
// the operand signs differ, and the remainder takes the dividend's sign.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   start_i       in   divide request, held by EX until ready_o is seen
//   annul_i       in   cancel (flush/exception); has priority over start_i
//   signed_div_i  in   1 = DIV (signed), 0 = DIVU; sampled at acceptance
//   opdata1_i     in   dividend; sampled at acceptance
//   opdata2_i     in   divisor; sampled at acceptance
//   result_o      out  {remainder, quotient}; valid while ready_o = 1
//   ready_o       out  result valid (registered)
//   busy_o        out  sequencer not idle (registered); EX uses it as a stall
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_dend;    // dividend magnitude, shifts out MSB first; quotient bits shift in at LSB
  logic [WIDTH-1:0]   r_dsor;    // divisor magnitude
  logic [WIDTH-1:0]   r_part;    // partial remainder (always < divisor after each step)
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign1;
  logic               r_sign2;
  logic               r_signed;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_part_nxt;
  logic [WIDTH-1:0]   w_dend_nxt;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic               w_last;

  // One restoring step. The shifted partial is WIDTH+1 bits so the compare and
  // subtract never lose the bit shifted out of the top.
  always_comb begin
    w_shift    = {r_part, r_dend[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dsor};
    w_ge       = (w_shift >= {1'b0, r_dsor});
    w_part_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_dend_nxt = {r_dend[WIDTH-2:0], w_ge};
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Sign fixups applied on the final step, using the values being produced on
  // that same edge so the result registers together with ready_o.
  always_comb begin
    w_q_fix = w_dend_nxt;
    w_r_fix = w_part_nxt;
    if (r_signed && (r_sign1 ^ r_sign2)) begin
      w_q_fix = '0 - w_dend_nxt;
    end
    if (r_signed && r_sign1) begin
      w_r_fix = '0 - w_part_nxt;
    end
  end

  // Operand magnitudes captured at acceptance.
  always_comb begin
    w_abs1 = opdata1_i;
    w_abs2 = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      w_abs1 = '0 - opdata1_i;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      w_abs2 = '0 - opdata2_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_dend   <= '0;
      r_dsor   <= '0;
      r_part   <= '0;
      r_cnt    <= '0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_signed <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          if (annul_i) begin
            r_busy <= 1'b0;
          end else if (start_i) begin
            r_dend   <= w_abs1;
            r_dsor   <= w_abs2;
            r_part   <= '0;
            r_cnt    <= '0;
            r_sign1  <= opdata1_i[WIDTH-1];
            r_sign2  <= opdata2_i[WIDTH-1];
            r_signed <= signed_div_i;
            r_busy   <= 1'b1;
            r_state  <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_BYZERO: begin
          if (annul_i) begin
            r_state <= S_FREE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
          end else begin
            r_state  <= S_END;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end

        S_ON: begin
          if (annul_i) begin
            r_state  <= S_FREE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
            r_part   <= '0;
            r_cnt    <= '0;
          end else begin
            r_part <= w_part_nxt;
            r_dend <= w_dend_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_state  <= S_END;
              r_result <= {w_r_fix, w_q_fix};
              r_ready  <= 1'b1;
            end
          end
        end

        S_END: begin
          if (annul_i || !start_i) begin
            r_state  <= S_FREE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
          end
        end

        default: begin
          r_state  <= S_FREE;
          r_busy   <= 1'b0;
          r_ready  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = r_busy;

endmodule
